// File: rtl/ram_dp_resp.sv
// Dual-port RAM responder: write-first collision bypass, clears its array after every reset.
// Optional macro RAM_PARITY_EN adds a per-word even-parity bit and the rd_perr output.
//
// state | meaning
// INIT  | clear sweep writing zero to every word; requests ignored
// RUN   | normal write/read service
`timescale 1ns/1ps
module ram_dp_resp #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_enb,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              init_busy,
  output logic [15:0]       coll_cnt
`ifdef RAM_PARITY_EN
  ,
  output logic              rd_perr
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [15:0]       coll_q, coll_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok, rd_ok, coll;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  // Range checks are done on the full address; the array is indexed with the low bits only.
  assign wr_ok  = wr_enb && (32'(wr_addr) < DEPTH);
  assign rd_ok  = 32'(rd_addr) < DEPTH;
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];
  assign coll   = wr_ok && rd_enb && rd_ok && (wr_addr == rd_addr);

`ifdef RAM_PARITY_EN
  logic par_mem [DEPTH];
  logic perr_q, perr_d;
  logic mem_wpar;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    coll_d    = coll_q;
    mem_we    = 1'b0;
    mem_idx   = wr_idx;
    mem_wdata = data_in;
`ifdef RAM_PARITY_EN
    perr_d    = 1'b0;
    mem_wpar  = ^data_in;
`endif
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_idx   = ptr_q;
        mem_wdata = '0;
`ifdef RAM_PARITY_EN
        mem_wpar  = 1'b0;
`endif
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) state_d = RUN;
      end
      RUN: begin
        mem_we = wr_ok;
        if (rd_enb) begin
          valid_d = 1'b1;
          if (!rd_ok)    data_d = '0;
          else if (coll) data_d = data_in;
          else           data_d = mem[rd_idx];
`ifdef RAM_PARITY_EN
          perr_d = rd_ok && !coll && ((^mem[rd_idx]) != par_mem[rd_idx]);
`endif
        end
        if (coll && (coll_q != 16'hFFFF)) coll_d = coll_q + 16'd1;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
`ifdef RAM_PARITY_EN
      par_mem[mem_idx] <= mem_wpar;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      coll_q  <= '0;
`ifdef RAM_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      coll_q  <= coll_d;
`ifdef RAM_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign rd_valid  = valid_q;
  assign init_busy = (state_q == INIT);
  assign coll_cnt  = coll_q;
`ifdef RAM_PARITY_EN
  assign rd_perr   = perr_q;
`endif

endmodule

// File: tb/tb_ram_dp_resp.sv
// Directed bench for ram_dp_resp (DEPTH=16, ADDR_W=5): vector table plus reset/sweep/saturation sequences.
`timescale 1ns/1ps
module tb_ram_dp_resp;

  logic        clk;
  logic        rst_n;
  logic        wr_enb;
  logic [4:0]  wr_addr;
  logic [63:0] data_in;
  logic        rd_enb;
  logic [4:0]  rd_addr;
  logic [63:0] data_out;
  logic        rd_valid;
  logic        init_busy;
  logic [15:0] coll_cnt;
`ifdef RAM_PARITY_EN
  logic        rd_perr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ram_dp_resp #(.DATA_W(64), .ADDR_W(5), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_enb    (wr_enb),
    .wr_addr   (wr_addr),
    .data_in   (data_in),
    .rd_enb    (rd_enb),
    .rd_addr   (rd_addr),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .init_busy (init_busy),
    .coll_cnt  (coll_cnt)
`ifdef RAM_PARITY_EN
    ,
    .rd_perr   (rd_perr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic        ev;
    logic [63:0] ed;
    logic [15:0] ec;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                              input logic re, input logic [4:0] ra,
                              input logic ev, input logic [63:0] ed, input logic [15:0] ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.ev = ev; v.ed = ed; v.ec = ec;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic re, input logic [4:0] ra);
    wr_enb = we; wr_addr = wa; data_in = wd; rd_enb = re; rd_addr = ra;
  endtask

  task automatic wait_sweep(output int cnt);
    cnt = 0;
    while (init_busy && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    step();
    step();
    chk("reset data_out", data_out, 64'd0);
    chk("reset rd_valid", 64'(rd_valid), 64'd0);
    chk("reset init_busy", 64'(init_busy), 64'd1);
    chk("reset coll_cnt", 64'(coll_cnt), 64'd0);

    // Release reset with requests held active through the whole sweep; all must be ignored.
    rst_n = 1'b1;
    drive(1'b1, 5'd3, 64'h1, 1'b1, 5'd3);
    cnt = 0;
    while (init_busy && cnt < 100) begin
      step();
      cnt++;
      chk("init no rd_valid", 64'(rd_valid), 64'd0);
    end
    chk("sweep length", 64'(cnt), 64'd16);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);

    for (int i = 0; i < 16; i++) add(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b1, 64'd0, 16'd0);
    add(1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 1'b0, 5'd0,  1'b0, 64'd0,                 16'd0);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd5,  1'b1, 64'hDEAD_BEEF_0123_4567, 16'd0);
    add(1'b0, 5'd0,  64'd0,                   1'b0, 5'd0,  1'b0, 64'hDEAD_BEEF_0123_4567, 16'd0);
    add(1'b1, 5'd7,  64'hA5A5,                1'b1, 5'd7,  1'b1, 64'hA5A5,              16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd7,  1'b1, 64'hA5A5,              16'd1);
    add(1'b1, 5'd20, 64'hFF,                  1'b1, 5'd20, 1'b1, 64'd0,                 16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd4,  1'b1, 64'd0,                 16'd1);
    add(1'b1, 5'd9,  64'h1234,                1'b1, 5'd5,  1'b1, 64'hDEAD_BEEF_0123_4567, 16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd9,  1'b1, 64'h1234,              16'd1);
    add(1'b1, 5'd16, 64'hFF,                  1'b0, 5'd0,  1'b0, 64'h1234,              16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd0,  1'b1, 64'd0,                 16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd31, 1'b1, 64'd0,                 16'd1);
    add(1'b1, 5'd5,  64'hCAFE,                1'b1, 5'd9,  1'b1, 64'h1234,              16'd1);
    add(1'b0, 5'd0,  64'd0,                   1'b1, 5'd5,  1'b1, 64'hCAFE,              16'd1);

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re, tv[i].ra);
      step();
      chk($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(tv[i].ev));
      chk($sformatf("vec%0d data_out", i), data_out, tv[i].ed);
      chk($sformatf("vec%0d coll_cnt", i), 64'(coll_cnt), 64'(tv[i].ec));
`ifdef RAM_PARITY_EN
      chk($sformatf("vec%0d rd_perr", i), 64'(rd_perr), 64'd0);
`endif
    end

    // Collision counter saturation; count is already 1 from the table.
    drive(1'b1, 5'd7, 64'hA5A5, 1'b1, 5'd7);
    for (int k = 1; k <= 70000; k++) begin
      step();
      if (k == 65533) chk("coll_cnt near sat", 64'(coll_cnt), 64'hFFFE);
      if (k == 65534) chk("coll_cnt at sat", 64'(coll_cnt), 64'hFFFF);
    end
    chk("coll_cnt saturated", 64'(coll_cnt), 64'hFFFF);
    chk("coll data_out", data_out, 64'hA5A5);
    chk("coll rd_valid", 64'(rd_valid), 64'd1);

    // Reset asserted while a read is pending.
    drive(1'b1, 5'd2, 64'h55, 1'b0, 5'd0);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst rd_valid", 64'(rd_valid), 64'd0);
    chk("midrst data_out", data_out, 64'd0);
    chk("midrst init_busy", 64'(init_busy), 64'd1);
    chk("midrst coll_cnt", 64'(coll_cnt), 64'd0);
    step();
    chk("midrst held rd_valid", 64'(rd_valid), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    wait_sweep(cnt);
    chk("resweep length", 64'(cnt), 64'd16);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2);
    step();
    chk("after rst addr2 valid", 64'(rd_valid), 64'd1);
    chk("after rst addr2 data", data_out, 64'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    step();
    chk("after rst addr7 data", data_out, 64'd0);
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    step();
    chk("idle rd_valid", 64'(rd_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
